// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR sequencer state encoding and default datapath sizing
// used by the sequencer, MAC unit and sample/coefficient memories.
package fir_pkg;

   localparam int unsigned FIR_N_TAPS  = 32;
   localparam int unsigned FIR_ADDR_W  = 5;
   localparam int unsigned FIR_DATA_W  = 16;
   localparam int unsigned FIR_MAC_LAT = 2;
   localparam int unsigned OVR_CNT_W   = 8;
   localparam int unsigned LAT_W       = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      MAC   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } fir_state_t;

endpackage

// File: rtl/fir_tick_sync.sv
// fir_tick_sync: brings the 48 kHz sample-clock level into the clk domain
// and emits a one-cycle tick on each rising edge, 3 clk after the edge.
module fir_tick_sync (
   input  logic clk,
   input  logic reset,
   input  logic clk_muestreo,
   output logic tick
);

   logic [1:0] sync_q;
   logic       hist_q;

   // Two-flop synchroniser plus edge history; preset high so a level that is
   // already high when reset releases is not seen as an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= 2'b11;
         hist_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], clk_muestreo};
         hist_q <= sync_q[1];
      end
   end

   // Registered rising-edge strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick <= 1'b0;
      end else begin
         tick <= sync_q[1] & ~hist_q;
      end
   end

endmodule

// File: rtl/fir_secuenciador.sv
// fir_secuenciador: control sequencer for the FIR audio filter. On each sample
// tick it writes the new sample into the circular sample RAM, then walks the
// MAC through all taps, waits out the MAC pipeline and pulses out_valid.
// Optional build macro FIR_OVR_CNT_EN adds a saturating dropped-tick counter
// on port ovr_cnt.
module fir_secuenciador
   import fir_pkg::*;
#(
   parameter int unsigned N_TAPS  = FIR_N_TAPS,
   parameter int unsigned ADDR_W  = FIR_ADDR_W,
   parameter int unsigned DATA_W  = FIR_DATA_W,
   parameter int unsigned MAC_LAT = FIR_MAC_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_muestreo,
   input  logic [DATA_W-1:0] din,
   input  logic              ovr_clr,
   output logic              smp_we,
   output logic [ADDR_W-1:0] smp_addr,
   output logic [DATA_W-1:0] smp_wdata,
   output logic [ADDR_W-1:0] coef_addr,
   output logic              mac_clr,
   output logic              mac_en,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun
`ifdef FIR_OVR_CNT_EN
   ,
   output logic [OVR_CNT_W-1:0] ovr_cnt
`endif
);

   localparam int unsigned LAT_LAST = (MAC_LAT == 0) ? 0 : MAC_LAT - 1;
   localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_TAPS - 1);

   fir_state_t        state_q, state_nx;
   logic [ADDR_W-1:0] k_q, k_nx;
   logic [LAT_W-1:0]  lat_q, lat_nx;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_nx;

   logic              smp_we_nx;
   logic [ADDR_W-1:0] smp_addr_nx;
   logic [DATA_W-1:0] smp_wdata_nx;
   logic [ADDR_W-1:0] coef_addr_nx;
   logic              mac_clr_nx;
   logic              mac_en_nx;
   logic              out_valid_nx;

   logic              tick;
   logic              drop_c;

   fir_tick_sync u_tick_sync (
      .clk          (clk),
      .reset        (reset),
      .clk_muestreo (clk_muestreo),
      .tick         (tick)
   );

   // A tick that arrives outside IDLE is dropped and flagged
   assign drop_c = tick & (state_q != IDLE);

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         k_q       <= '0;
         lat_q     <= '0;
         wr_ptr_q  <= '0;
         smp_we    <= 1'b0;
         smp_addr  <= '0;
         smp_wdata <= '0;
         coef_addr <= '0;
         mac_clr   <= 1'b0;
         mac_en    <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_nx;
         k_q       <= k_nx;
         lat_q     <= lat_nx;
         wr_ptr_q  <= wr_ptr_nx;
         smp_we    <= smp_we_nx;
         smp_addr  <= smp_addr_nx;
         smp_wdata <= smp_wdata_nx;
         coef_addr <= coef_addr_nx;
         mac_clr   <= mac_clr_nx;
         mac_en    <= mac_en_nx;
         out_valid <= out_valid_nx;
         busy      <= (state_nx != IDLE);
      end
   end

   // Next state plus the output values that belong to that next state
   always_comb begin
      state_nx     = state_q;
      k_nx         = k_q;
      lat_nx       = lat_q;
      wr_ptr_nx    = wr_ptr_q;
      smp_we_nx    = 1'b0;
      mac_en_nx    = 1'b0;
      mac_clr_nx   = 1'b0;
      out_valid_nx = 1'b0;
      smp_addr_nx  = smp_addr;
      coef_addr_nx = coef_addr;
      smp_wdata_nx = smp_wdata;

      case (state_q)
         IDLE: begin
            if (tick) begin
               state_nx     = WRITE;
               smp_we_nx    = 1'b1;
               smp_addr_nx  = wr_ptr_q;
               smp_wdata_nx = din;
            end
         end
         WRITE: begin
            state_nx     = MAC;
            k_nx         = '0;
            mac_en_nx    = 1'b1;
            mac_clr_nx   = 1'b1;
            coef_addr_nx = '0;
            smp_addr_nx  = wr_ptr_q;
         end
         MAC: begin
            if (k_q == K_LAST) begin
               lat_nx = '0;
               if (MAC_LAT == 0) begin
                  state_nx     = DONE;
                  out_valid_nx = 1'b1;
               end else begin
                  state_nx = DRAIN;
               end
            end else begin
               k_nx         = k_q + ADDR_W'(1);
               mac_en_nx    = 1'b1;
               coef_addr_nx = k_nx;
               smp_addr_nx  = wr_ptr_q - k_nx;
            end
         end
         DRAIN: begin
            if (lat_q == LAT_W'(LAT_LAST)) begin
               state_nx     = DONE;
               out_valid_nx = 1'b1;
            end else begin
               lat_nx = lat_q + LAT_W'(1);
            end
         end
         DONE: begin
            state_nx  = IDLE;
            wr_ptr_nx = wr_ptr_q + ADDR_W'(1);
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Sticky overrun; a dropped tick beats a simultaneous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun <= 1'b0;
      end else if (drop_c) begin
         overrun <= 1'b1;
      end else if (ovr_clr) begin
         overrun <= 1'b0;
      end
   end

`ifdef FIR_OVR_CNT_EN
   // Saturating dropped-tick counter; a drop during clear restarts it at 1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovr_cnt <= '0;
      end else if (drop_c) begin
         if (ovr_clr) begin
            ovr_cnt <= OVR_CNT_W'(1);
         end else if (ovr_cnt != '1) begin
            ovr_cnt <= ovr_cnt + OVR_CNT_W'(1);
         end
      end else if (ovr_clr) begin
         ovr_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_fir_secuenciador.sv
// tb_fir_secuenciador: directed bench for the FIR control sequencer with
// hand-derived expected addresses, strobes and latencies.
module tb_fir_secuenciador;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clk_muestreo = 1'b1;
   logic [15:0] din = '0;
   logic        ovr_clr = 1'b0;
   logic        smp_we;
   logic [4:0]  smp_addr;
   logic [15:0] smp_wdata;
   logic [4:0]  coef_addr;
   logic        mac_clr;
   logic        mac_en;
   logic        out_valid;
   logic        busy;
   logic        overrun;
`ifdef FIR_OVR_CNT_EN
   logic [7:0]  ovr_cnt;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [4:0]  wp;

   fir_secuenciador #(
      .N_TAPS  (32),
      .ADDR_W  (5),
      .DATA_W  (16),
      .MAC_LAT (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .clk_muestreo (clk_muestreo),
      .din          (din),
      .ovr_clr      (ovr_clr),
      .smp_we       (smp_we),
      .smp_addr     (smp_addr),
      .smp_wdata    (smp_wdata),
      .coef_addr    (coef_addr),
      .mac_clr      (mac_clr),
      .mac_en       (mac_en),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun)
`ifdef FIR_OVR_CNT_EN
      ,
      .ovr_cnt      (ovr_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One full sequence from a fresh rising edge; optional mid-MAC edge
   // injection (inj) and an ovr_clr pulse on MAC cycle clr_at.
   task automatic run_seq(input logic [15:0] d, input logic [4:0] wptr,
                          input int inj, input int clr_at);
      logic [4:0] ea;
      din = d;
      clk_muestreo = 1'b1;
      step(3);
      chk("pre_busy", busy, 0);
      step(1);
      chk("wr_we", smp_we, 1);
      chk("wr_addr", smp_addr, wptr);
      chk("wr_data", smp_wdata, d);
      chk("wr_mac_en", mac_en, 0);
      chk("wr_busy", busy, 1);
      clk_muestreo = 1'b0;
      for (int k = 0; k < 32; k++) begin
         step(1);
         ovr_clr = 1'b0;
         ea = wptr - 5'(k);
         chk("mac_en", mac_en, 1);
         chk("mac_clr", mac_clr, (k == 0) ? 1 : 0);
         chk("mac_coef", coef_addr, k);
         chk("mac_smp_addr", smp_addr, ea);
         chk("mac_we", smp_we, 0);
         chk("mac_ov", out_valid, 0);
         if (inj >= 0 && k == inj)     clk_muestreo = 1'b1;
         if (inj >= 0 && k == inj + 6) clk_muestreo = 1'b0;
         if (k == clr_at)              ovr_clr = 1'b1;
      end
      ea = wptr - 5'd31;
      for (int i = 0; i < 2; i++) begin
         step(1);
         ovr_clr = 1'b0;
         chk("drain_en", mac_en, 0);
         chk("drain_clr", mac_clr, 0);
         chk("drain_ov", out_valid, 0);
         chk("drain_coef", coef_addr, 31);
         chk("drain_addr", smp_addr, ea);
         chk("drain_busy", busy, 1);
      end
      step(1);
      chk("done_ov", out_valid, 1);
      chk("done_busy", busy, 1);
      chk("done_en", mac_en, 0);
      step(1);
      chk("idle_ov", out_valid, 0);
      chk("idle_busy", busy, 0);
      step(2);
   endtask

   initial begin
      // reset with sample clock high: nothing may start after release
      step(3);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("rst_strobes", {smp_we, mac_en, mac_clr, out_valid, busy, overrun}, 0);
         chk("rst_addr", {smp_addr, coef_addr}, 0);
         chk("rst_wdata", smp_wdata, 0);
      end
`ifdef FIR_OVR_CNT_EN
      chk("rst_cnt", ovr_cnt, 0);
`endif
      clk_muestreo = 1'b0;
      step(3);

      // first sequence from wr_ptr 0
      wp = 5'd0;
      run_seq(16'h1234, wp, -1, -1);
      wp = wp + 5'd1;

      // edge injected mid-MAC is dropped and flagged
      chk("ovr_before", overrun, 0);
      run_seq(16'habcd, wp, 5, -1);
      wp = wp + 5'd1;
      chk("ovr_set", overrun, 1);
`ifdef FIR_OVR_CNT_EN
      chk("cnt_one", ovr_cnt, 1);
`endif
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0;
      chk("ovr_clr", overrun, 0);
`ifdef FIR_OVR_CNT_EN
      chk("cnt_clr", ovr_cnt, 0);
`endif

      // clear coinciding with a dropped tick: set wins
      run_seq(16'h0f0f, wp, 3, 6);
      wp = wp + 5'd1;
      chk("ovr_same_cycle", overrun, 1);
`ifdef FIR_OVR_CNT_EN
      chk("cnt_same_cycle", ovr_cnt, 1);
`endif
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0;

      // reset asserted at k=10 of a sequence starting at wr_ptr 3
      din = 16'h5a5a;
      clk_muestreo = 1'b1;
      step(4);
      chk("mr_we", smp_we, 1);
      chk("mr_addr", smp_addr, 3);
      clk_muestreo = 1'b0;
      step(11);
      chk("mr_k10_coef", coef_addr, 10);
      chk("mr_k10_addr", smp_addr, 25);
      reset = 1'b0;
      #1;
      chk("mr_async_strobes", {smp_we, mac_en, mac_clr, out_valid, busy}, 0);
      chk("mr_async_addr", {smp_addr, coef_addr}, 0);
      step(2);
      chk("mr_hold_ov", out_valid, 0);
      reset = 1'b1;
      step(3);
      wp = 5'd0;
      run_seq(16'h2222, wp, -1, -1);
      wp = wp + 5'd1;

      // walk wr_ptr up to 31, then across the wrap
      while (wp != 5'd31) begin
         run_seq(16'(wp * 257), wp, -1, -1);
         wp = wp + 5'd1;
      end
      run_seq(16'hbeef, wp, -1, -1);
      wp = wp + 5'd1;
      chk("wrap_ptr", wp, 0);
      run_seq(16'hcafe, wp, -1, -1);

`ifdef FIR_OVR_CNT_EN
      // flood of edges: counter saturates at 255
      for (int i = 0; i < 700; i++) begin
         clk_muestreo = ~clk_muestreo;
         step(1);
      end
      clk_muestreo = 1'b0;
      step(5);
      for (int i = 0; i < 100; i++) begin
         if (!busy) break;
         step(1);
      end
      chk("flood_idle", busy, 0);
      chk("flood_cnt", ovr_cnt, 255);
      chk("flood_ovr", overrun, 1);
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0;
      chk("flood_cnt_clr", ovr_cnt, 0);
      chk("flood_ovr_clr", overrun, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
